// File: rtl/ram_sp_core.sv
// -----------------------------------------------------------------------------
// ram_sp_core
//   Single-port synchronous RAM (DEPTH x DATA_WIDTH) with one shared address
//   bus. Writes are clocked. Reads are registered with one cycle of latency.
//   On a write cycle the output register takes the write data, so the write
//   is seen on dout in the same cycle (write-first).
//   An asynchronous active-low reset clears dout and every word of the array.
//
// Ports (positional order is fixed: din, clk, addr, we, dout, rst_n)
//   din   in  DATA_WIDTH  write data
//   clk   in  1           rising-edge clock
//   addr  in  ADDR_WIDTH  shared read/write word address
//   we    in  1           1 = write cycle, 0 = read cycle
//   dout  out DATA_WIDTH  registered read data
//   rst_n in  1           asynchronous active-low reset
//
// rst_n is the last port so that older five-port positional instantiations
// still elaborate with it left unconnected. A floating (z) rst_n makes
// !rst_n evaluate to x. The reset branch is then not taken, so only a clean
// logic 0 holds the block in reset.
// -----------------------------------------------------------------------------
module ram_sp_core #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rst_n
);

    // The address must cover the array exactly. There is no out-of-range case.
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("ram_sp_core: DEPTH must equal 2**ADDR_WIDTH");
    end

    // Storage. The name is kept as ram so that benches can reach the words
    // hierarchically.
    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    // Next value for the output register.
    logic [DATA_WIDTH-1:0] dout_d;

    // NOTE: combinational blocks assign every output on every path, default
    // first, so no latch is inferred.
    always_comb begin
        dout_d = ram[addr];
        if (we) begin
            dout_d = din;       // write-first: the new data goes straight out
        end
    end

    // NOTE: the array is cleared by the asynchronous reset. This forces the
    // storage into flops rather than a RAM macro, which is acceptable at this
    // size and is required for the clear-on-reset behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // only, so every reader sees the pre-edge values.
            dout <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else begin
            dout <= dout_d;
            if (we) begin
                ram[addr] <= din;   // din is stored as-is, including x bits
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_core.sv
// -----------------------------------------------------------------------------
// tb_ram_sp_core
//   Table-driven bench for ram_sp_core. Each vector is driven on the falling
//   edge, and its expected dout is pushed to a scoreboard queue. The value is
//   popped and compared 1 ns after the following rising edge. Hand-written
//   sequences cover these cases:
//     - the reset pulse
//     - a reset that lands on a write cycle
//     - a mid-cycle change of addr and din
//   Array contents are checked through hierarchical reads of dut.ram.
// -----------------------------------------------------------------------------
module tb_ram_sp_core;

    logic       clk;
    logic       rst_n;
    logic [4:0] din;
    logic [3:0] addr;
    logic       we;
    logic [4:0] dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [4:0] din;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t       tbl_a[$];
    vec_t       tbl_b[$];
    logic [4:0] sb_q[$];
    logic [4:0] exp_mem [16];

    ram_sp_core dut (
        .din   (din),
        .clk   (clk),
        .addr  (addr),
        .we    (we),
        .dout  (dout),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one access. The expected dout is pushed when the access is
    // driven, then popped after the edge.
    task automatic apply(input vec_t v);
        logic [4:0] e;
        @(negedge clk);
        we   = v.we;
        addr = v.addr;
        din  = v.din;
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got none, want one entry", v.name);
        end else begin
            e = sb_q.pop_front();
            check(v.name, dout, e);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s ram[%0d]", tag, i), dut.ram[i], exp_mem[i]);
        end
    endtask

    task automatic clear_exp_mem();
        for (int i = 0; i < 16; i++) exp_mem[i] = 5'd0;
    endtask

    initial begin
        // Phase A: writes, readbacks, and reads that must not write.
        tbl_a.push_back('{1'b1, 4'd0,  5'd5,  5'd5,  "wr a0"});
        tbl_a.push_back('{1'b1, 4'd1,  5'd6,  5'd6,  "wr a1"});
        tbl_a.push_back('{1'b1, 4'd9,  5'd13, 5'd13, "wr a9"});
        tbl_a.push_back('{1'b1, 4'd15, 5'd7,  5'd7,  "wr a15"});
        tbl_a.push_back('{1'b0, 4'd0,  5'd0,  5'd5,  "rd a0"});
        tbl_a.push_back('{1'b0, 4'd1,  5'd0,  5'd6,  "rd a1"});
        tbl_a.push_back('{1'b0, 4'd9,  5'd0,  5'd13, "rd a9"});
        tbl_a.push_back('{1'b0, 4'd15, 5'd0,  5'd7,  "rd a15"});
        tbl_a.push_back('{1'b0, 4'd5,  5'd6,  5'd0,  "nowr a5 #1"});
        tbl_a.push_back('{1'b0, 4'd5,  5'd6,  5'd0,  "nowr a5 #2"});
        tbl_a.push_back('{1'b0, 4'd5,  5'd6,  5'd0,  "nowr a5 #3"});
        tbl_a.push_back('{1'b0, 4'd7,  5'd6,  5'd0,  "nowr a7 #1"});
        tbl_a.push_back('{1'b0, 4'd7,  5'd6,  5'd0,  "nowr a7 #2"});

        // Phase B: write-through, overwrite, and we held at one address.
        tbl_b.push_back('{1'b1, 4'd3,  5'd21, 5'd21, "wt wr a3"});
        tbl_b.push_back('{1'b0, 4'd3,  5'd0,  5'd21, "wt rd a3"});
        tbl_b.push_back('{1'b1, 4'd9,  5'd13, 5'd13, "ow wr a9=13"});
        tbl_b.push_back('{1'b1, 4'd9,  5'd2,  5'd2,  "ow wr a9=2"});
        tbl_b.push_back('{1'b0, 4'd9,  5'd0,  5'd2,  "ow rd a9"});
        tbl_b.push_back('{1'b1, 4'd8,  5'd1,  5'd1,  "hold a8 d1"});
        tbl_b.push_back('{1'b1, 4'd8,  5'd2,  5'd2,  "hold a8 d2"});
        tbl_b.push_back('{1'b1, 4'd8,  5'd3,  5'd3,  "hold a8 d3"});
        tbl_b.push_back('{1'b0, 4'd8,  5'd0,  5'd3,  "hold rd a8"});
        tbl_b.push_back('{1'b0, 4'd15, 5'd0,  5'd7,  "rd a15 again"});

        // Initial reset.
        we = 1'b0; addr = 4'd0; din = 5'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset dout", dout, 5'd0);
        clear_exp_mem();
        check_mem("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset pulse between edges, after a write of 5 to address 0.
        apply('{1'b1, 4'd0, 5'd5, 5'd5, "pre-pulse wr a0"});
        @(negedge clk);
        we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("pulse dout immediate", dout, 5'd0);
        #1 rst_n = 1'b1;
        #1;
        check_mem("after pulse");

        // A reset that is held across a write edge cancels the write.
        @(negedge clk);
        we = 1'b1; addr = 4'd2; din = 5'd9;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset-write dout", dout, 5'd0);
        check("reset-write ram[2]", dut.ram[2], 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b0;

        // Phase A, then a dump of the array.
        foreach (tbl_a[i]) apply(tbl_a[i]);
        clear_exp_mem();
        exp_mem[0] = 5'b00101; exp_mem[1] = 5'b00110;
        exp_mem[9] = 5'b01101; exp_mem[15] = 5'b00111;
        check_mem("dump A");

        foreach (tbl_b[i]) apply(tbl_b[i]);

        // A change to addr between edges must not reach dout until the
        // next rising edge.
        apply('{1'b0, 4'd0, 5'd0, 5'd5, "edge rd a0"});
        #2 addr = 4'd1;
        #1;
        check("edge addr hold", dout, 5'd5);
        @(posedge clk);
        #1;
        check("edge addr next", dout, 5'd6);

        // A change to din between edges: only the value present at the
        // rising edge is stored.
        @(negedge clk);
        we = 1'b1; addr = 4'd4; din = 5'd10;
        #2 din = 5'd11;
        @(posedge clk);
        #1;
        check("edge din dout", dout, 5'd11);
        check("edge din ram[4]", dut.ram[4], 5'd11);
        apply('{1'b0, 4'd4, 5'd0, 5'd11, "edge rd a4"});

        // Final contents of the array.
        exp_mem[3] = 5'd21; exp_mem[4] = 5'd11;
        exp_mem[8] = 5'd3;  exp_mem[9] = 5'b00010;
        check_mem("dump final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
